cdb_arbiter: RTL and testbench

- Arbitrates the common data bus (CDB) among NUM_REQ functional units returning results in the dynamic out-of-order core.
- Each unit gets a one-entry holding buffer. A round-robin arbiter selects one buffered result per cycle and drives the registered cdb_valid/cdb_tag/cdb_data broadcast.
- The issue queue and the register status logic consume that broadcast to wake up waiting operands.

---
 rtl/cdb_pkg.sv | 23 ++
 rtl/cdb_arbiter_rr.sv | 52 +++++
 rtl/cdb_arbiter.sv | 82 ++++++++
 tb/tb_cdb_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_pkg.sv
`default_nettype none
//============================================================================
// Module   : cdb_pkg
// Desc     : Shared CDB widths, packet type and round-robin index helper.
// Revision : 1.0
//============================================================================
package cdb_pkg;

    localparam int CDB_TAG_WIDTH  = 4;
    localparam int CDB_DATA_WIDTH = 32;

    typedef struct packed {
        logic [CDB_TAG_WIDTH-1:0]  tag;
        logic [CDB_DATA_WIDTH-1:0] data;
    } cdb_pkt_t;

    // Wrap is an explicit compare so non-power-of-2 unit counts work.
    function automatic logic rr_is_last(input int unsigned idx, input int unsigned num);
        return (idx == num - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cdb_arbiter_rr.sv
`default_nettype none
//============================================================================
// Module   : rr_arbiter
// Desc     : Round-robin one-hot arbiter; owns the pointer, advances on grant.
// Revision : 1.0
//============================================================================
module rr_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int IDX_WIDTH = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NUM_REQ-1:0]   req,
    input  logic                 advance,
    output logic [NUM_REQ-1:0]   grant,
    output logic [IDX_WIDTH-1:0] winner,
    output logic                 any_grant
);

    logic [IDX_WIDTH-1:0] r_rr_ptr;
    logic [IDX_WIDTH-1:0] w_idx;
    logic [IDX_WIDTH-1:0] w_ptr_next;

    always_comb begin
        grant     = '0;
        winner    = '0;
        any_grant = 1'b0;
        w_idx     = r_rr_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!any_grant && req[w_idx]) begin
                any_grant    = 1'b1;
                grant[w_idx] = 1'b1;
                winner       = w_idx;
            end
            w_idx = rr_is_last(32'(w_idx), NUM_REQ) ? '0 : w_idx + IDX_WIDTH'(1);
        end
    end

    assign w_ptr_next = rr_is_last(32'(winner), NUM_REQ) ? '0 : winner + IDX_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rr_ptr <= '0;
        end else if (advance && any_grant) begin
            r_rr_ptr <= w_ptr_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
//============================================================================
// Module   : cdb_arbiter
// Desc     : Per-unit one-entry result buffers drained round-robin onto the CDB.
// Revision : 1.0
//============================================================================
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = CDB_DATA_WIDTH,
    parameter int TAG_WIDTH  = CDB_TAG_WIDTH,
    parameter int SRC_WIDTH  = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          flush,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*TAG_WIDTH-1:0]  req_tag,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic                          cdb_valid,
    output logic [TAG_WIDTH-1:0]          cdb_tag,
    output logic [DATA_WIDTH-1:0]         cdb_data,
    output logic [SRC_WIDTH-1:0]          cdb_src
);

    logic [NUM_REQ-1:0]    r_buf_valid;
    logic [TAG_WIDTH-1:0]  r_buf_tag  [NUM_REQ];
    logic [DATA_WIDTH-1:0] r_buf_data [NUM_REQ];

    logic [NUM_REQ-1:0]    w_grant;
    logic [SRC_WIDTH-1:0]  w_winner;
    logic                  w_any_grant;
    logic [NUM_REQ-1:0]    w_xfer;

    rr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .IDX_WIDTH (SRC_WIDTH)
    ) u_rr_arbiter (
        .clk       (clk),
        .resetn    (resetn),
        .req       (r_buf_valid),
        .advance   (~flush),
        .grant     (w_grant),
        .winner    (w_winner),
        .any_grant (w_any_grant)
    );

    // A granted buffer frees this edge, so it can reload in the same cycle.
    assign req_ready = {NUM_REQ{resetn & ~flush}} & (~r_buf_valid | w_grant);
    assign w_xfer    = req_valid & req_ready;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_xfer[i]) begin
                r_buf_tag[i]  <= req_tag[i*TAG_WIDTH +: TAG_WIDTH];
                r_buf_data[i] <= req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        if (!resetn) begin
            r_buf_valid <= '0;
            cdb_valid   <= 1'b0;
            cdb_tag     <= '0;
            cdb_data    <= '0;
            cdb_src     <= '0;
        end else if (flush) begin
            r_buf_valid <= '0;
            cdb_valid   <= 1'b0;
        end else begin
            r_buf_valid <= w_xfer | (r_buf_valid & ~w_grant);
            cdb_valid   <= w_any_grant;
            if (w_any_grant) begin
                cdb_tag  <= r_buf_tag[w_winner];
                cdb_data <= r_buf_data[w_winner];
                cdb_src  <= w_winner;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
//============================================================================
// Module   : tb_cdb_arbiter
// Desc     : Random + directed bench for cdb_arbiter at NUM_REQ=4 and NUM_REQ=3.
// Revision : 1.0
//============================================================================
module tb_cdb_arbiter;

    logic         clk = 1'b0;
    logic         resetn;
    logic         flush;
    logic [3:0]   req_valid;
    logic [15:0]  req_tag;
    logic [127:0] req_data;

    logic [3:0]   ready4;
    logic         cv4;
    logic [3:0]   ct4;
    logic [31:0]  cd4;
    logic [1:0]   cs4;

    logic [2:0]   ready3;
    logic         cv3;
    logic [3:0]   ct3;
    logic [31:0]  cd3;
    logic [1:0]   cs3;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    cdb_arbiter #(.NUM_REQ(4)) u_dut4 (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (ready4),
        .req_tag   (req_tag),
        .req_data  (req_data),
        .cdb_valid (cv4),
        .cdb_tag   (ct4),
        .cdb_data  (cd4),
        .cdb_src   (cs4)
    );

    cdb_arbiter #(.NUM_REQ(3)) u_dut3 (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush),
        .req_valid (req_valid[2:0]),
        .req_ready (ready3),
        .req_tag   (req_tag[11:0]),
        .req_data  (req_data[95:0]),
        .cdb_valid (cv3),
        .cdb_tag   (ct3),
        .cdb_data  (cd3),
        .cdb_src   (cs3)
    );

    // Reference: each unit has a slot that is empty or holds one result.
    bit          m_pend [2][4];
    logic [3:0]  m_tag  [2][4];
    logic [31:0] m_data [2][4];
    int          m_ptr  [2];
    bit          m_cv   [2];
    logic [3:0]  m_ct   [2];
    logic [31:0] m_cd   [2];
    int          m_cs   [2];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic int m_win(input int inst, input int n);
        for (int k = 0; k < n; k++) begin
            if (m_pend[inst][(m_ptr[inst] + k) % n]) return (m_ptr[inst] + k) % n;
        end
        return -1;
    endfunction

    function automatic logic [31:0] m_ready(input int inst, input int n);
        logic [31:0] r;
        int w;
        r = '0;
        w = m_win(inst, n);
        for (int i = 0; i < n; i++)
            r[i] = resetn && !flush && (!m_pend[inst][i] || w == i);
        return r;
    endfunction

    task automatic m_edge(input int inst, input int n);
        int          w;
        logic [31:0] rdy;
        w   = m_win(inst, n);
        rdy = m_ready(inst, n);
        if (!resetn) begin
            for (int i = 0; i < 4; i++) m_pend[inst][i] = 1'b0;
            m_ptr[inst] = 0;
            m_cv[inst]  = 1'b0;
            m_ct[inst]  = '0;
            m_cd[inst]  = '0;
            m_cs[inst]  = 0;
        end else if (flush) begin
            for (int i = 0; i < 4; i++) m_pend[inst][i] = 1'b0;
            m_cv[inst] = 1'b0;
        end else begin
            m_cv[inst] = (w >= 0);
            if (w >= 0) begin
                m_ct[inst]  = m_tag[inst][w];
                m_cd[inst]  = m_data[inst][w];
                m_cs[inst]  = w;
                m_ptr[inst] = (w + 1) % n;
                m_pend[inst][w] = 1'b0;
            end
            for (int i = 0; i < n; i++) begin
                if (req_valid[i] && rdy[i]) begin
                    m_pend[inst][i] = 1'b1;
                    m_tag[inst][i]  = req_tag[i*4 +: 4];
                    m_data[inst][i] = req_data[i*32 +: 32];
                end
            end
        end
    endtask

    task automatic check_all();
        chk("ready4", 32'(ready4), m_ready(0, 4));
        chk("cdb_valid4", 32'(cv4), 32'(m_cv[0]));
        chk("cdb_tag4", 32'(ct4), 32'(m_ct[0]));
        chk("cdb_data4", cd4, m_cd[0]);
        chk("cdb_src4", 32'(cs4), 32'(m_cs[0]));
        chk("ready3", 32'(ready3), m_ready(1, 3));
        chk("cdb_valid3", 32'(cv3), 32'(m_cv[1]));
        chk("cdb_tag3", 32'(ct3), 32'(m_ct[1]));
        chk("cdb_data3", cd3, m_cd[1]);
        chk("cdb_src3", 32'(cs3), 32'(m_cs[1]));
    endtask

    task automatic step(input bit rn, input bit fl, input logic [3:0] v,
                        input logic [15:0] t, input logic [127:0] d);
        @(negedge clk);
        resetn    = rn;
        flush     = fl;
        req_valid = v;
        req_tag   = t;
        req_data  = d;
        #1;
        check_all();
        @(posedge clk);
        m_edge(0, 4);
        m_edge(1, 3);
    endtask

    task automatic idle(input int cycles);
        for (int c = 0; c < cycles; c++) step(1'b1, 1'b0, 4'b0, 16'h0, 128'h0);
    endtask

    initial begin
        logic [3:0]   rv;
        logic [15:0]  rt;
        logic [127:0] rd;
        bit           rrn;
        bit           rfl;

        resetn    = 1'b0;
        flush     = 1'b0;
        req_valid = '0;
        req_tag   = '0;
        req_data  = '0;
        @(posedge clk);
        m_edge(0, 4);
        m_edge(1, 3);
        step(1'b0, 1'b0, 4'b0, 16'h0, 128'h0);
        #1;
        chk("reset_valid", 32'(cv4), 32'd0);
        chk("reset_tag", 32'(ct4), 32'd0);
        chk("reset_src", 32'(cs4), 32'd0);

        // Single uncontended result from unit 2.
        step(1'b1, 1'b0, 4'b0100, {4'd0, 4'd5, 8'd0}, {32'd0, 32'hDEADBEEF, 64'd0});
        step(1'b1, 1'b0, 4'b0000, 16'h0, 128'h0);
        #1;
        chk("single_valid", 32'(cv4), 32'd1);
        chk("single_tag", 32'(ct4), 32'd5);
        chk("single_data", cd4, 32'hDEADBEEF);
        chk("single_src", 32'(cs4), 32'd2);
        step(1'b1, 1'b0, 4'b0000, 16'h0, 128'h0);
        #1;
        chk("single_pulse", 32'(cv4), 32'd0);
        idle(2);

        // All-request burst.
        step(1'b1, 1'b0, 4'b1111, {4'd4, 4'd3, 4'd2, 4'd1}, {32'd44, 32'd33, 32'd22, 32'd11});
        idle(6);

        // Back-to-back from unit 1.
        for (int k = 0; k < 4; k++)
            step(1'b1, 1'b0, 4'b0010, 16'((6 + k) << 4), 128'(32'(100 + k)) << 32);
        idle(3);

        // Fairness between units 0 and 3.
        for (int k = 0; k < 8; k++)
            step(1'b1, 1'b0, 4'b1001, {4'(k + 8), 8'd0, 4'(k)}, {32'(k + 300), 64'd0, 32'(k + 200)});
        idle(3);

        // Flush mid-drain.
        step(1'b1, 1'b0, 4'b1111, 16'hABCD, {32'd1, 32'd2, 32'd3, 32'd4});
        idle(1);
        step(1'b1, 1'b1, 4'b1111, 16'h1234, 128'h5);
        idle(4);

        // Reset mid-operation, then the NUM_REQ=3 wrap.
        step(1'b1, 1'b0, 4'b1111, 16'h7777, 128'h77);
        step(1'b0, 1'b0, 4'b1111, 16'h8888, 128'h88);
        #1;
        chk("midreset_valid3", 32'(cv3), 32'd0);
        chk("midreset_src3", 32'(cs3), 32'd0);
        step(1'b1, 1'b0, 4'b0100, 16'h0900, {32'd0, 32'd9, 64'd0});
        idle(2);
        step(1'b1, 1'b0, 4'b0101, 16'h0a0b, {32'd0, 32'd10, 32'd0, 32'd11});
        step(1'b1, 1'b0, 4'b0101, 16'h0c0d, {32'd0, 32'd12, 32'd0, 32'd13});
        idle(4);

        // Randomized traffic.
        for (int c = 0; c < 2000; c++) begin
            rv  = 4'($urandom);
            if (c % 200 < 100) rv = rv | 4'($urandom);
            rt  = 16'($urandom);
            rd  = {$urandom, $urandom, $urandom, $urandom};
            rrn = ($urandom % 64) != 0;
            rfl = ($urandom % 16) == 0;
            step(rrn, rfl, rv, rt, rd);
        end
        idle(5);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
